lsu_mem_ctrl: RTL and testbench
===============================

# lsu_mem_ctrl

Load/store unit placed directly upstream of the byte-addressed data/instruction RAM in the RV32I core. It accepts one load or store per request handshake from the execute stage and decodes RV32I `funct3` into RAM byte-lane enables and store data. It also sign- or zero-extends load data and returns it through a response handshake. Illegal, misaligned and out-of-range accesses are screened before any write reaches the RAM.

## Interface
Parameters:
- `ADDR_WIDTH`, 17: RAM byte-address width; memory spans 0 .. 2^ADDR_WIDTH-1.

Ports:
- `clk`  in  1  single clock, rising edge; the RAM acts on the falling edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept; high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3.
- `req_addr`  in  ADDR_WIDTH  byte address.
- `req_wdata`  in  32  store data, LSB-justified.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  access rejected, no RAM write performed.
- `mem_raddr`, `mem_waddr`  out  ADDR_WIDTH  RAM addresses.
- `mem_wdata`  out  32  RAM write data.
- `mem_wea`  out  4  RAM byte enables.
- `mem_rdata`  in  32  RAM read data, valid after the falling edge.

## Operation
- FSM states are IDLE, ACCESS and RESP.
  - IDLE → ACCESS on `req_valid & req_ready`. Request fields are registered on that edge.
  - ACCESS → RESP on the next edge, unconditionally.
  - RESP → IDLE on the edge where `rsp_ready` is high. Otherwise RESP holds, with `rsp_rdata` and `rsp_err` stable.
- Size decode from `funct3`:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - All other codes are illegal and set `rsp_err`.
- Stores drive `mem_waddr = addr`, `mem_wdata = req_wdata`, and `mem_wea` = 0001 / 0011 / 1111 for byte / half / word.
- Loads drive `mem_raddr = addr`. Result at the ACCESS→RESP edge:
  - LB: sign-extend `mem_rdata[7:0]`. LBU: zero-extend `mem_rdata[7:0]`.
  - LH: sign-extend `mem_rdata[15:0]`. LHU: zero-extend `mem_rdata[15:0]`.
  - LW: `mem_rdata` unchanged.
- Range check: the access is rejected (`rsp_err` = 1) if `addr + size - 1 > 2^ADDR_WIDTH - 1`. The sum is computed at ADDR_WIDTH+1 bits so it cannot wrap.
- Any error (illegal code, range, misalignment when enabled) takes the same path:
  - The request still passes through ACCESS, with `mem_wea` forced to 0000.
  - `rsp_rdata` = 0.
- `mem_wea` is 0000 outside ACCESS. `mem_raddr` and `mem_waddr` always reflect the registered address.

## Timing
- Reset values: state IDLE, `req_ready` 1, `rsp_valid` 0, `rsp_rdata` 0, `rsp_err` 0, `mem_wea` 0000. Address and data registers reset to 0.
- Request accepted at rising edge E0. The RAM write or read happens on the falling edge inside the E0–E1 cycle.
- `rsp_valid` rises after E1, giving a 1-cycle latency. Minimum spacing between accepted requests is 3 cycles.
- `req_ready` is low in ACCESS and RESP; `req_valid` arriving then is ignored.
- A RESP→IDLE transition does not accept a new request on the same edge.
- `rst` mid-operation: return to IDLE and drop the response at the next edge.
  - A write whose falling edge precedes that rising edge has already been committed.
  - No further `mem_wea` pulse is issued.

## Configuration
- `LSU_MISALIGN_TRAP_EN`:
  - Defined: a halfword access with `addr[0]` = 1, or a word access with `addr[1:0]` ≠ 00, sets `rsp_err` and performs no write.
  - Undefined: misaligned accesses proceed as normal. The RAM assembles bytes from any byte address, so the result is exact. Only the range and illegal-code checks remain.

## Test plan
- SW 0xDEADBEEF to 0x100, then LW 0x100 → `rsp_rdata` 0xDEADBEEF, `rsp_err` 0, `rsp_valid` one cycle after acceptance.
- SB 0xAABBCCDD to 0x101 over word 0x00000000 at 0x100, then LW 0x100 → 0x0000DD00; `mem_wea` was 0001 during ACCESS only.
- Byte 0x80 at 0x200: LB → 0xFFFFFF80, LBU → 0x00000080. Halfword 0x8001: LH → 0xFFFF8001, LHU → 0x00008001.
- LH at 0x203:
  - With `LSU_MISALIGN_TRAP_EN` → `rsp_err` 1, `rsp_rdata` 0.
  - Without it → correct halfword from bytes 0x203–0x204.
  - SW at 0x1FFFE (ADDR_WIDTH 17) → `rsp_err` 1, no RAM change.
- Hold `rsp_ready` low for 5 cycles in RESP → `rsp_valid` and data stable, `req_ready` 0. Assert `rst` during ACCESS → IDLE next edge, `rsp_valid` never asserted.
- Illegal `funct3` 011 load and 100 store → `rsp_err` 1, `mem_wea` 0000 throughout.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// RV32I load/store unit in front of a byte-addressed RAM with falling-edge access.
// Optional misalignment trap is enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_mem_ctrl #(
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wea,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  state_t                state_r, state_s;
  logic                  ready_r, rsp_valid_r, rsp_err_r, err_r, we_r;
  logic [2:0]            funct3_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [31:0]           wdata_r, rsp_rdata_r;
  logic [3:0]            wea_r, mask_s;
  logic [ADDR_WIDTH:0]   off_s, last_s;
  logic                  accept_s, misalign_s, err_s;

  // Lane mask of a legal access; all-zero marks an illegal funct3 for that direction
  function automatic logic [3:0] size_mask(input logic we, input logic [2:0] f3);
    logic [3:0] m;
    m = 4'b0000;
    case (f3)
      3'b000:  m = 4'b0001;
      3'b001:  m = 4'b0011;
      3'b010:  m = 4'b1111;
      3'b100:  m = we ? 4'b0000 : 4'b0001;
      3'b101:  m = we ? 4'b0000 : 4'b0011;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    r = 32'h0000_0000;
    case (f3)
      3'b000:  r = {{24{d[7]}}, d[7:0]};
      3'b001:  r = {{16{d[15]}}, d[15:0]};
      3'b010:  r = d;
      3'b100:  r = {24'h00_0000, d[7:0]};
      3'b101:  r = {16'h0000, d[15:0]};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Screen the incoming request: illegal code, range overflow, optional misalignment
  always_comb begin
    accept_s = req_valid & ready_r;
    mask_s   = size_mask(req_we, req_funct3);
    off_s    = '0;
    case (mask_s)
      4'b0011: off_s = {{(ADDR_WIDTH-1){1'b0}}, 2'b01};
      4'b1111: off_s = {{(ADDR_WIDTH-1){1'b0}}, 2'b11};
      default: off_s = '0;
    endcase
    last_s = {1'b0, req_addr} + off_s;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_s = ((mask_s == 4'b0011) & req_addr[0]) |
                 ((mask_s == 4'b1111) & (req_addr[1:0] != 2'b00));
`else
    misalign_s = 1'b0;
`endif
    err_s = (mask_s == 4'b0000) | last_s[ADDR_WIDTH] | misalign_s;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = ACCESS;
        else          state_s = IDLE;
      end
      ACCESS: state_s = RESP;
      RESP: begin
        if (rsp_ready) state_s = IDLE;
        else           state_s = RESP;
      end
      default: state_s = IDLE;
    endcase
  end

  // Request capture, single-cycle byte-enable pulse and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_r     <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      err_r       <= 1'b0;
      we_r        <= 1'b0;
      funct3_r    <= 3'b000;
      addr_r      <= '0;
      wdata_r     <= 32'h0000_0000;
      wea_r       <= 4'b0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            ready_r  <= 1'b0;
            err_r    <= err_s;
            we_r     <= req_we;
            funct3_r <= req_funct3;
            addr_r   <= req_addr;
            wdata_r  <= req_wdata;
            wea_r    <= (req_we & ~err_s) ? mask_s : 4'b0000;
          end
        end
        ACCESS: begin
          wea_r       <= 4'b0000;
          rsp_valid_r <= 1'b1;
          rsp_err_r   <= err_r;
          // mem_rdata has settled from the falling edge inside this cycle
          rsp_rdata_r <= (err_r | we_r) ? 32'h0000_0000 : load_extend(funct3_r, mem_rdata);
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            ready_r     <= 1'b1;
          end
        end
        default: begin
          ready_r     <= 1'b1;
          rsp_valid_r <= 1'b0;
          wea_r       <= 4'b0000;
        end
      endcase
    end
  end

  assign req_ready = ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  assign rsp_rdata = rsp_rdata_r;
  assign mem_raddr = addr_r;
  assign mem_waddr = addr_r;
  assign mem_wdata = wdata_r;
  assign mem_wea   = wea_r;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: byte-array RAM plus a reference model
// that applies the access rules directly to its own byte array.
`timescale 1ns/1ps
module tb_lsu_mem_ctrl;
  localparam int AW    = 17;
  localparam int MEMSZ = 1 << AW;

  logic          clk = 1'b0;
  logic          rst, req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr, mem_raddr, mem_waddr;
  logic [31:0]   req_wdata, rsp_rdata, mem_wdata, mem_rdata;
  logic [3:0]    mem_wea;

  logic [7:0] ram     [0:MEMSZ-1];
  logic [7:0] ref_mem [0:MEMSZ-1];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    int          addr;
    logic [31:0] wd;
    logic        cc;
    logic [31:0] exp;
  } op_t;

  lsu_mem_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_wea(mem_wea), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM acts on the falling edge; reads assemble four bytes from any byte address
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++)
      if (mem_wea[i]) ram[(int'(mem_waddr) + i) % MEMSZ] <= mem_wdata[8*i +: 8];
    mem_rdata <= {ram[(int'(mem_raddr) + 3) % MEMSZ], ram[(int'(mem_raddr) + 2) % MEMSZ],
                  ram[(int'(mem_raddr) + 1) % MEMSZ], ram[int'(mem_raddr)]};
  end

  // Reference: what a load/store should do to memory and what it should return
  task automatic model(input logic we, input logic [2:0] f3, input int a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output logic [3:0] wea);
    int size;
    bit sgn, legal;
    logic [31:0] v;
    size = 1; sgn = 0; legal = 1; v = 32'h0;
    if (we) begin
      if (f3 == 3'd0) size = 1;
      else if (f3 == 3'd1) size = 2;
      else if (f3 == 3'd2) size = 4;
      else legal = 0;
    end else begin
      case (f3)
        3'd0: begin size = 1; sgn = 1; end
        3'd1: begin size = 2; sgn = 1; end
        3'd2: size = 4;
        3'd4: size = 1;
        3'd5: size = 2;
        default: legal = 0;
      endcase
    end
    er = !legal || (a + size - 1 > MEMSZ - 1);
`ifdef LSU_MISALIGN_TRAP_EN
    if (legal && size > 1 && (a % size) != 0) er = 1'b1;
`endif
    rd = 32'h0; wea = 4'h0;
    if (!er) begin
      if (we) begin
        for (int i = 0; i < size; i++) ref_mem[a + i] = wd[8*i +: 8];
        wea = 4'((1 << size) - 1);
      end else begin
        for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[a + i];
        if (sgn && v[8*size - 1]) v = v | (32'hFFFF_FFFF << (8*size));
        rd = v;
      end
    end
  endtask

  // Drives one request, drives junk while busy, returns what was observed
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [AW-1:0] a,
                        input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic er, output int lat,
                        output logic [3:0] wea0, output int wea_n, output logic stable,
                        output logic busy_ready, output logic to);
    int w;
    to = 0; stable = 1; busy_ready = 0; wea_n = 0; lat = 0; w = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && w < 10) begin @(negedge clk); w++; end
    if (w >= 10) to = 1;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_we = 1'($urandom_range(0, 1));
    req_funct3 = 3'($urandom_range(0, 7));
    req_addr = AW'(768 + $urandom_range(0, 63));
    req_wdata = $urandom;
    @(negedge clk);
    wea0 = mem_wea;
    if (mem_wea !== 4'h0) wea_n++;
    if (req_ready !== 1'b0) busy_ready = 1;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (mem_wea !== 4'h0) wea_n++;
      if (req_ready !== 1'b0) busy_ready = 1;
    end
    if (lat >= 20) to = 1;
    rd = rsp_rdata; er = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_err !== er) stable = 0;
      if (req_ready !== 1'b0) busy_ready = 1;
      if (mem_wea !== 4'h0) wea_n++;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0; rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; req_we = 1'b0;
    req_funct3 = 3'd0; req_addr = '0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
    checks++; if (mem_wea !== 4'h0) begin errors++; $display("FAIL reset_mem_wea got %b want 0000", mem_wea); end
    checks++; if (mem_waddr !== '0 || mem_raddr !== '0) begin errors++; $display("FAIL reset_addr got %h/%h want 0", mem_waddr, mem_raddr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", mem_wdata); end
    rst = 1'b0;
  endtask

  task automatic test_directed;
    op_t ops[$];
    logic [31:0] erd, rd; logic eer, er, stb, br, to; logic [3:0] ewea, wea0; int lat, wn;
    ops.push_back('{1'b1, 3'd2, 'h100,   32'hDEADBEEF, 1'b1, 32'h0});
    ops.push_back('{1'b0, 3'd2, 'h100,   32'h0,        1'b1, 32'hDEADBEEF});
    ops.push_back('{1'b1, 3'd2, 'h100,   32'h0,        1'b0, 32'h0});
    ops.push_back('{1'b1, 3'd0, 'h101,   32'hAABBCCDD, 1'b0, 32'h0});
    ops.push_back('{1'b0, 3'd2, 'h100,   32'h0,        1'b1, 32'h0000DD00});
    ops.push_back('{1'b1, 3'd0, 'h200,   32'h00000080, 1'b0, 32'h0});
    ops.push_back('{1'b0, 3'd0, 'h200,   32'h0,        1'b1, 32'hFFFFFF80});
    ops.push_back('{1'b0, 3'd4, 'h200,   32'h0,        1'b1, 32'h00000080});
    ops.push_back('{1'b1, 3'd1, 'h200,   32'h00008001, 1'b0, 32'h0});
    ops.push_back('{1'b0, 3'd1, 'h200,   32'h0,        1'b1, 32'hFFFF8001});
    ops.push_back('{1'b0, 3'd5, 'h200,   32'h0,        1'b1, 32'h00008001});
    ops.push_back('{1'b1, 3'd2, 'h204,   32'h11223344, 1'b0, 32'h0});
    ops.push_back('{1'b1, 3'd0, 'h203,   32'h0000005A, 1'b0, 32'h0});
    ops.push_back('{1'b0, 3'd1, 'h203,   32'h0,        1'b0, 32'h0});
    ops.push_back('{1'b1, 3'd2, 'h1FFFE, 32'h12345678, 1'b1, 32'h0});
    ops.push_back('{1'b0, 3'd0, 'h1FFFF, 32'h0,        1'b0, 32'h0});
    ops.push_back('{1'b0, 3'd1, 'h1FFFF, 32'h0,        1'b1, 32'h0});
    ops.push_back('{1'b0, 3'd3, 'h300,   32'h0,        1'b1, 32'h0});
    ops.push_back('{1'b1, 3'd4, 'h300,   32'hCAFEF00D, 1'b1, 32'h0});
    ops.push_back('{1'b1, 3'd3, 'h304,   32'hCAFEF00D, 1'b1, 32'h0});
    ops.push_back('{1'b0, 3'd6, 'h300,   32'h0,        1'b1, 32'h0});
    foreach (ops[k]) begin
      model(ops[k].we, ops[k].f3, ops[k].addr, ops[k].wd, erd, eer, ewea);
      run_op(ops[k].we, ops[k].f3, AW'(ops[k].addr), ops[k].wd, 0, rd, er, lat, wea0, wn, stb, br, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL dir%0d_timeout got %b want 0", k, to); end
      checks++; if (rd !== erd) begin errors++; $display("FAIL dir%0d_rdata got %h want %h", k, rd, erd); end
      checks++; if (er !== eer) begin errors++; $display("FAIL dir%0d_err got %b want %b", k, er, eer); end
      checks++; if (wea0 !== ewea) begin errors++; $display("FAIL dir%0d_wea got %b want %b", k, wea0, ewea); end
      checks++; if (wn != ((ewea != 4'h0) ? 1 : 0)) begin errors++; $display("FAIL dir%0d_wea_cycles got %0d want %0d", k, wn, (ewea != 4'h0) ? 1 : 0); end
      checks++; if (lat != 1) begin errors++; $display("FAIL dir%0d_latency got %0d want 1", k, lat); end
      if (ops[k].cc) begin
        checks++; if (rd !== ops[k].exp) begin errors++; $display("FAIL dir%0d_const got %h want %h", k, rd, ops[k].exp); end
      end
    end
  endtask

  task automatic test_stall;
    logic [31:0] erd, rd; logic eer, er, stb, br, to; logic [3:0] ewea, wea0; int lat, wn;
    model(1'b0, 3'd2, 'h100, 32'h0, erd, eer, ewea);
    run_op(1'b0, 3'd2, AW'('h100), 32'h0, 5, rd, er, lat, wea0, wn, stb, br, to);
    checks++; if (stb !== 1'b1) begin errors++; $display("FAIL stall_stable got %b want 1", stb); end
    checks++; if (br !== 1'b0) begin errors++; $display("FAIL stall_req_ready got %b want 0", br); end
    checks++; if (rd !== erd) begin errors++; $display("FAIL stall_rdata got %h want %h", rd, erd); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] wd, erd, rd; logic eer, er, stb, br, to; logic [3:0] ewea, wea0; int lat, wn, seen;
    wd = $urandom;
    model(1'b1, 3'd2, 'h320, wd, erd, eer, ewea);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = AW'('h320); req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checks++; if (mem_wea !== 4'hF) begin errors++; $display("FAIL rstmid_wea got %b want 1111", mem_wea); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_wea !== 4'h0) begin
      errors++; $display("FAIL rstmid_idle got valid=%b ready=%b wea=%b want 0/1/0000", rsp_valid, req_ready, mem_wea);
    end
    rst = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || mem_wea !== 4'h0) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rstmid_quiet got %0d active cycles want 0", seen); end
    model(1'b0, 3'd2, 'h320, 32'h0, erd, eer, ewea);
    run_op(1'b0, 3'd2, AW'('h320), 32'h0, 0, rd, er, lat, wea0, wn, stb, br, to);
    checks++; if (rd !== wd) begin errors++; $display("FAIL rstmid_committed got %h want %h", rd, wd); end
  endtask

  task automatic test_random;
    logic [31:0] erd, rd, wd; logic eer, er, stb, br, to, we; logic [3:0] ewea, wea0;
    logic [2:0] f3; int lat, wn, a, hold;
    for (int n = 0; n < 80; n++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      wd = $urandom;
      hold = $urandom_range(0, 2);
      if ($urandom_range(0, 7) == 0) a = MEMSZ - 1 - $urandom_range(0, 5);
      else a = 768 + $urandom_range(0, 63);
      model(we, f3, a, wd, erd, eer, ewea);
      run_op(we, f3, AW'(a), wd, hold, rd, er, lat, wea0, wn, stb, br, to);
      checks++; if (to !== 1'b0 || lat != 1) begin errors++; $display("FAIL rnd%0d_latency got %0d want 1", n, lat); end
      checks++; if (rd !== erd || er !== eer) begin
        errors++; $display("FAIL rnd%0d_rsp we=%b f3=%0d a=%h got %h/%b want %h/%b", n, we, f3, a, rd, er, erd, eer);
      end
      checks++; if (wea0 !== ewea || wn != ((ewea != 4'h0) ? 1 : 0)) begin
        errors++; $display("FAIL rnd%0d_wea got %b x%0d want %b", n, wea0, wn, ewea);
      end
      checks++; if (stb !== 1'b1 || br !== 1'b0) begin errors++; $display("FAIL rnd%0d_hold got stable=%b ready=%b want 1/0", n, stb, br); end
    end
  endtask

  task automatic test_memory;
    int bad;
    bad = 0;
    for (int i = 'h100; i < 'h340; i++) if (ram[i] !== ref_mem[i]) bad++;
    for (int i = MEMSZ - 8; i < MEMSZ; i++) if (ram[i] !== ref_mem[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL memory_image got %0d differing bytes want 0", bad); end
  endtask

  initial begin
    for (int i = 0; i < MEMSZ; i++) begin
      ram[i] = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid();
    test_random();
    test_memory();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
